// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P channel-0 type definitions used by the read engine.
// Field layout follows the shell's request/response headers.
package ccip_if_pkg;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [15:0]  t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

endpackage

// File: rtl/pipearch_memread.sv
// Streams a contiguous run of cache lines from host memory over CCI-P c0 and
// hands each returned line to the local buffer tagged by its line index.
module pipearch_memread
  import ccip_if_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int NUM_REGS        = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_start,
  output logic           op_done,
  output logic           busy,
  input  logic [31:0]    regs [NUM_REGS],
  input  t_ccip_clAddr   in_addr,
  input  t_ccip_clAddr   out_addr,
  input  logic           c0TxAlmFull,
  input  t_if_ccip_c0_Rx cp2af_sRx_c0,
  output t_if_ccip_c0_Tx af2cp_sTx_c0,
  output logic           out_wvalid,
  output logic [15:0]    out_waddr,
  output t_ccip_clData   out_wdata,
  output logic [3:0]     dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} t_send_state;
  typedef enum logic [1:0] {R_IDLE, R_RECV, R_DONE} t_recv_state;

  localparam logic [8:0] MAX_OS = 9'(MAX_OUTSTANDING);

  t_send_state        send_state;
  t_recv_state        recv_state;
  t_ccip_clAddr       start_addr;
  logic [15:0]        length;
  logic [15:0]        sent;
  logic [15:0]        received;
  logic [8:0]         outstanding;
  t_ccip_c0_ReqMemHdr req_hdr;

  logic start_ok;
  logic zero_len;
  logic issue;
  logic rsp_count;

  assign start_ok  = op_start && !busy && send_state == S_IDLE && recv_state == R_IDLE;
  assign zero_len  = regs[2][15:0] == 16'd0;
  assign issue     = send_state == S_READ && !c0TxAlmFull && outstanding < MAX_OS;
  // Out-of-range indices are stale traffic; they neither deliver nor return credit.
  assign rsp_count = recv_state == R_RECV && cp2af_sRx_c0.rspValid &&
                     cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE &&
                     cp2af_sRx_c0.hdr.mdata < length;

  assign dbg_state = {send_state, recv_state};

  always_comb begin
    req_hdr          = '0;
    req_hdr.vc_sel   = eVC_VA;
    req_hdr.cl_len   = eCL_LEN_1;
    req_hdr.req_type = eREQ_RDLINE_I;
    req_hdr.address  = start_addr + t_ccip_clAddr'(sent);
    req_hdr.mdata    = sent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      send_state   <= S_IDLE;
      recv_state   <= R_IDLE;
      start_addr   <= '0;
      length       <= '0;
      sent         <= '0;
      received     <= '0;
      outstanding  <= '0;
      busy         <= 1'b0;
      op_done      <= 1'b0;
      out_wvalid   <= 1'b0;
      out_waddr    <= '0;
      out_wdata    <= '0;
      af2cp_sTx_c0 <= '0;
    end else begin
      af2cp_sTx_c0.valid <= 1'b0;
      out_wvalid         <= 1'b0;
      op_done            <= 1'b0;

      if (start_ok) begin
        start_addr  <= (regs[1][31] ? out_addr : in_addr) + t_ccip_clAddr'(regs[1][30:0]);
        length      <= regs[2][15:0];
        sent        <= '0;
        received    <= '0;
        outstanding <= '0;
        busy        <= 1'b1;
      end else if (issue && !rsp_count) begin
        outstanding <= outstanding + 9'd1;
      end else if (!issue && rsp_count) begin
        outstanding <= outstanding - 9'd1;
      end

      case (send_state)
        S_IDLE: if (start_ok) send_state <= zero_len ? S_DONE : S_READ;
        S_READ: begin
          if (issue) begin
            af2cp_sTx_c0.valid <= 1'b1;
            af2cp_sTx_c0.hdr   <= req_hdr;
            sent               <= sent + 16'd1;
            if (sent == length - 16'd1) send_state <= S_DONE;
          end
        end
        S_DONE:  send_state <= S_IDLE;
        default: send_state <= S_IDLE;
      endcase

      case (recv_state)
        R_IDLE: if (start_ok) recv_state <= zero_len ? R_DONE : R_RECV;
        R_RECV: begin
          if (rsp_count) begin
            out_wvalid <= 1'b1;
            out_waddr  <= cp2af_sRx_c0.hdr.mdata;
            out_wdata  <= cp2af_sRx_c0.data;
            received   <= received + 16'd1;
            if (received + 16'd1 == length) recv_state <= R_DONE;
          end
        end
        R_DONE: begin
          op_done    <= 1'b1;
          busy       <= 1'b0;
          recv_state <= R_IDLE;
        end
        default: recv_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipearch_memread.md
# pipearch_memread

Read-side counterpart of the write-back stage: on `op_start` it streams a contiguous run of cache lines from host memory over CCI-P channel 0 and delivers each returned line to the on-chip buffer tagged with its line index. It sits between the CCI-P/MPF shell and the pipeline's local line buffers, issuing `eREQ_RDLINE_I` requests under a credit limit. It tolerates out-of-order responses by carrying the line index in `mdata`.

## Interface
- `MAX_OUTSTANDING`, default 64: maximum read requests in flight; legal range 1..255.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `op_start`  in  1  one-cycle start pulse, sampled only when idle.
- `op_done`  out  1  one-cycle pulse after the last line is delivered.
- `busy`  out  1  high from the cycle after an accepted `op_start` until the cycle `op_done` pulses.
- `regs`  in  32 x NUM_REGS  operation registers:
  - `regs[1][30:0]` is the line offset.
  - `regs[1][31]` selects the base: 0 = `in_addr`, 1 = `out_addr`.
  - `regs[2][15:0]` is the length in lines.
- `in_addr`, `out_addr`  in  t_ccip_clAddr  base line addresses.
- `c0TxAlmFull`  in  1  channel-0 transmit almost-full.
- `cp2af_sRx_c0`  in  t_if_ccip_c0_Rx  read responses.
- `af2cp_sTx_c0`  out  t_if_ccip_c0_Tx  read requests.
- `out_wvalid`  out  1  delivered line valid.
- `out_waddr`  out  16  line index, 0..length-1.
- `out_wdata`  out  t_ccip_clData  line data.

## Operation
- **Request header** (fixed):
  - `req_type` = eREQ_RDLINE_I, `vc_sel` = eVC_VA, `cl_len` = eCL_LEN_1.
  - `mdata[15:0]` = line index; all other header fields 0.
- **Start.** `op_start` while idle latches:
  - base + zero-extended `regs[1][30:0]` as the start address;
  - `regs[2][15:0]` as the length;
  - clears `sent`, `received` and `outstanding`.
- **Busy.** `op_start` is ignored while `busy`.
- **Send FSM: IDLE -> READ -> DONE -> IDLE.**
  - IDLE -> READ on an accepted start with length != 0; IDLE -> DONE if length == 0.
  - In READ, a request is issued in a cycle only when `!c0TxAlmFull` and `outstanding < MAX_OUTSTANDING`.
  - A request carries address = start + `sent` and `mdata` = `sent`; `sent` increments on each issue.
  - READ -> DONE after issuing index length-1.
  - DONE -> IDLE unconditionally.
- **Receive FSM: IDLE -> RECV -> DONE -> IDLE.** Entered on the same start, with the same length==0 shortcut.
  - In RECV, a response is accepted when `rspValid` is high and `hdr.resp_type == eRSP_RDLINE`.
  - An accepted response with `mdata < length` is delivered: `out_wvalid`=1, `out_waddr`=`mdata`, `out_wdata`=data. `received` then increments and `outstanding` decrements.
  - An accepted response with `mdata >= length` is discarded and not counted.
  - RECV -> DONE when a counted response brings `received` to length.
  - DONE pulses `op_done` and returns to IDLE.
- **Outstanding counter.** 9 bits. An issue and a response in the same cycle leave it unchanged.
- **Ignored responses.** Responses arriving while the receive FSM is IDLE (stale after reset) are dropped and produce no `out_wvalid`.
- **Arithmetic.** Address sums are modulo the t_ccip_clAddr width. The 16-bit counters never wrap because length ≤ 65535.

## Timing
- **Reset values:**
  - `af2cp_sTx_c0.valid` = 0, `out_wvalid` = 0, `op_done` = 0, `busy` = 0;
  - both FSMs IDLE; all counters 0.
  - Data and header outputs are don't-care while their valid is low.
- **Registered outputs.** Every output is registered; `af2cp_sTx_c0.valid`, `out_wvalid` and `op_done` default low each cycle.
- **Request latency.** With `op_start` high in cycle t, the first request appears no earlier than cycle t+2. After that, at most one request per cycle, back to back while credit is available and `c0TxAlmFull` is low.
- **Almost-full.** `c0TxAlmFull` sampled high in cycle c means no request is valid in cycle c+1.
- **Response latency.** A response in cycle r produces `out_wvalid` in cycle r+1.
- **Done timing.** If the final counted response arrives in cycle r, `op_done` is high in cycle r+2 and is never earlier than the final `out_wvalid`.
- **Zero length.** With length 0 and `op_start` in cycle t: `op_done` in cycle t+2, no requests issued.
- **Reset mid-operation.** Returns to the reset state in the next cycle; no `op_done` pulse. A new `op_start` is accepted the cycle after `reset` deasserts.

## Test plan
- **Basic read.** `in_addr`=0x1000, `regs[1]`=4, `regs[2]`=3, in-order responses -> requests to 0x1004/0x1005/0x1006 with `mdata` 0/1/2; `out_waddr` 0,1,2 with matching data; one `op_done` pulse 2 cycles after the 3rd response.
- **Base select.** `regs[1]`=0x80000002, `out_addr`=0x2000, length 1 -> single request to 0x2002.
- **Out of order.** Length 4, responses returned in `mdata` order 3,0,2,1 -> `out_waddr` sequence 3,0,2,1 with correct data; `op_done` only after the 4th response.
- **Credit and backpressure.** `MAX_OUTSTANDING`=2, length 5, responses withheld -> exactly 2 requests, then stall; each response releases one request. `c0TxAlmFull` held high for 5 cycles -> no `valid` during that window, resumes one cycle after it drops.
- **Zero length and busy.** Length 0 -> `op_done` at t+2, no requests. A second `op_start` while `busy` -> ignored, with no extra requests and no extra `op_done`.
- **Reset mid-run.** Length 8, reset after 3 requests -> all outputs 0 next cycle; late responses produce no `out_wvalid`. A fresh length-2 operation then completes normally.
